// File: rtl/alu_control_sequencer_if.sv
// -----------------------------------------------------------------------------
// alu_control_sequencer_if
//
// Purpose:
//   Bundles the signals between the hardwired control sequencer and the
//   datapath. The inputs are the instruction register contents and the memory
//   and stop handshakes. The outputs are the datapath control strobes and the
//   status flags.
//
// Modports:
//   master - the sequencer. It reads IR, Mem_ready and Stop, and drives the
//            strobes, register selects, ALU_op, Run and Illegal.
//   slave  - the datapath or stimulus side. It drives IR, Mem_ready and Stop,
//            and observes everything else.
//
// Signals:
//   IR        [31:0] instruction register (opcode IR[31:27], Ra/Rb/Rc below)
//   Mem_ready        memory has valid data on Mdatain this cycle
//   Stop             request to halt at the next instruction boundary
//   PCout .. Read    datapath strobes
//   Gra/Grb/Grc      register field select for the select-and-encode logic
//   Rin/Rout         write/drive the selected register
//   ALU_op    [3:0]  ALU operation code
//   Run              sequencing active
//   Illegal          one-cycle pulse on an undefined opcode
// -----------------------------------------------------------------------------
interface alu_control_sequencer_if;
    logic [31:0] IR;
    logic        Mem_ready;
    logic        Stop;

    logic        PCout;
    logic        Zlowout;
    logic        MDRout;
    logic        MARin;
    logic        Zin;
    logic        PCin;
    logic        MDRin;
    logic        IRin;
    logic        Yin;
    logic        IncPC;
    logic        Read;

    logic        Gra;
    logic        Grb;
    logic        Grc;
    logic        Rin;
    logic        Rout;

    logic [3:0]  ALU_op;
    logic        Run;
    logic        Illegal;

    modport master (
        input  IR, Mem_ready, Stop,
        output PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
               IncPC, Read, Gra, Grb, Grc, Rin, Rout, ALU_op, Run, Illegal
    );

    modport slave (
        output IR, Mem_ready, Stop,
        input  PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
               IncPC, Read, Gra, Grb, Grc, Rin, Rout, ALU_op, Run, Illegal
    );
endinterface

// File: rtl/alu_control_sequencer.sv
// -----------------------------------------------------------------------------
// alu_control_sequencer
//
// Purpose:
//   Hardwired control unit for the simple register datapath. It fetches an
//   instruction in T0..T2, waiting on Mem_ready during T1. It decodes the
//   opcode held in IR at T3. For R-format ALU instructions it runs the
//   Rb -> Y, Rc op Y -> Z, Z -> Ra sequence in T3..T5. nop and halt are
//   handled at T3, and undefined opcodes raise a one-cycle Illegal pulse.
//   A Stop request is held pending and takes effect only at an instruction
//   boundary.
//
// Ports:
//   Clock    rising-edge system clock
//   Reset_n  asynchronous active-low reset; forces state RST and zeroes all
//            outputs without waiting for a clock edge
//   ctl      alu_control_sequencer_if.master
//            inputs : IR[31:0], Mem_ready, Stop
//            outputs: datapath strobes, Gra/Grb/Grc, Rin/Rout, ALU_op[3:0],
//                     Run, Illegal
//
// Parameters:
//   OPW      opcode field width, taken from the top of IR
//
// All outputs are decoded combinationally from the state, the wait flag and
// IR. None of them is registered.
// -----------------------------------------------------------------------------
module alu_control_sequencer #(
    parameter int OPW = 5
) (
    input  logic                     Clock,
    input  logic                     Reset_n,
    alu_control_sequencer_if.master  ctl
);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    localparam logic [2:0] S_RST  = 3'd0;
    localparam logic [2:0] S_T0   = 3'd1;
    localparam logic [2:0] S_T1   = 3'd2;
    localparam logic [2:0] S_T2   = 3'd3;
    localparam logic [2:0] S_T3   = 3'd4;
    localparam logic [2:0] S_T4   = 3'd5;
    localparam logic [2:0] S_T5   = 3'd6;
    localparam logic [2:0] S_HALT = 3'd7;

    // -------------------------------------------------------------------------
    // Opcode map. The eight ALU instructions are contiguous, starting at
    // ALU_BASE. ALU_op is the offset from that base.
    // -------------------------------------------------------------------------
    localparam int             ALU_BASE = 3;
    localparam int             ALU_NUM  = 8;
    localparam logic [OPW-1:0] OP_NOP   = OPW'(26);
    localparam logic [OPW-1:0] OP_HALT  = OPW'(27);

    logic [2:0]         state_reg, state_next;
    logic               wait_reg, wait_next;        // set after the first T1 cycle
    logic               stop_pend_reg, stop_pend_next;

    logic [OPW-1:0]     opcode;
    logic [ALU_NUM-1:0] alu_hit;
    logic [3:0]         alu_code;
    logic               is_alu;
    logic               is_nop;
    logic               is_halt;
    logic               running;
    logic               unused_ir_bits;

    // -------------------------------------------------------------------------
    // Decode
    // -------------------------------------------------------------------------
    assign opcode = ctl.IR[31 -: OPW];

    // The register fields are consumed by the select-and-encode logic
    // downstream. This block only raises Gra/Grb/Grc, so the fields are not
    // used here.
    assign unused_ir_bits = ^ctl.IR[31-OPW:0];

    // Each ALU opcode gets its own one-hot match line.
    generate
        for (genvar gi = 0; gi < ALU_NUM; gi++) begin : g_alu_hit
            assign alu_hit[gi] = (opcode == OPW'(ALU_BASE + gi));
        end
    endgenerate

    always_comb begin
        alu_code = 4'd0;
        for (int i = 0; i < ALU_NUM; i++) begin
            if (alu_hit[i]) begin
                alu_code = 4'(i);
            end
        end
    end

    assign is_alu  = |alu_hit;
    assign is_nop  = (opcode == OP_NOP);
    assign is_halt = (opcode == OP_HALT);
    assign running = (state_reg == S_T0) || (state_reg == S_T1) ||
                     (state_reg == S_T2) || (state_reg == S_T3) ||
                     (state_reg == S_T4) || (state_reg == S_T5);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        wait_next      = 1'b0;
        stop_pend_next = stop_pend_reg;

        // A Stop request is sticky. It only matters at an instruction
        // boundary, so a fetch in progress always completes.
        if (running && ctl.Stop) begin
            stop_pend_next = 1'b1;
        end

        case (state_reg)
            S_RST: state_next = S_T0;
            S_T0:  state_next = S_T1;
            S_T1: begin
                if (ctl.Mem_ready) begin
                    state_next = S_T2;
                end else begin
                    wait_next = 1'b1;
                end
            end
            S_T2:  state_next = S_T3;
            S_T3: begin
                if (is_alu) begin
                    state_next = S_T4;
                end else if (is_halt) begin
                    state_next = S_HALT;
                end else begin
                    // nop and undefined opcodes end the instruction here.
                    state_next = stop_pend_reg ? S_HALT : S_T0;
                end
            end
            S_T4:  state_next = S_T5;
            S_T5:  state_next = (stop_pend_reg || ctl.Stop) ? S_HALT : S_T0;
            S_HALT: state_next = S_HALT;
            default: state_next = S_RST;
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg     <= S_RST;
            wait_reg      <= 1'b0;
            stop_pend_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wait_reg      <= wait_next;
            stop_pend_reg <= stop_pend_next;
        end
    end

    // -------------------------------------------------------------------------
    // Output decode
    // -------------------------------------------------------------------------
    always_comb begin
        ctl.PCout   = 1'b0;
        ctl.Zlowout = 1'b0;
        ctl.MDRout  = 1'b0;
        ctl.MARin   = 1'b0;
        ctl.Zin     = 1'b0;
        ctl.PCin    = 1'b0;
        ctl.MDRin   = 1'b0;
        ctl.IRin    = 1'b0;
        ctl.Yin     = 1'b0;
        ctl.IncPC   = 1'b0;
        ctl.Read    = 1'b0;
        ctl.Gra     = 1'b0;
        ctl.Grb     = 1'b0;
        ctl.Grc     = 1'b0;
        ctl.Rin     = 1'b0;
        ctl.Rout    = 1'b0;
        ctl.ALU_op  = 4'd0;
        ctl.Run     = running;
        ctl.Illegal = 1'b0;

        case (state_reg)
            S_T0: begin
                // PC -> MAR, with PC+1 captured in Z.
                ctl.PCout = 1'b1;
                ctl.MARin = 1'b1;
                ctl.IncPC = 1'b1;
                ctl.Zin   = 1'b1;
            end
            S_T1: begin
                // PC is updated from Z once only. Wait cycles keep the memory
                // read alive without touching PC again.
                ctl.Zlowout = !wait_reg;
                ctl.PCin    = !wait_reg;
                ctl.Read    = 1'b1;
                ctl.MDRin   = 1'b1;
            end
            S_T2: begin
                ctl.MDRout = 1'b1;
                ctl.IRin   = 1'b1;
            end
            S_T3: begin
                if (is_alu) begin
                    ctl.Grb  = 1'b1;
                    ctl.Rout = 1'b1;
                    ctl.Yin  = 1'b1;
                end else if (!is_nop && !is_halt) begin
                    ctl.Illegal = 1'b1;
                end
            end
            S_T4: begin
                ctl.Grc    = 1'b1;
                ctl.Rout   = 1'b1;
                ctl.Zin    = 1'b1;
                ctl.ALU_op = alu_code;
            end
            S_T5: begin
                ctl.Zlowout = 1'b1;
                ctl.Gra     = 1'b1;
                ctl.Rin     = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
